// File: rtl/viterbi_link_sched.sv
// viterbi_link_sched
// Frame scheduler that shares one rate-1/2 encoder -> channel -> Viterbi
// decoder link between NREQ requesters. A round-robin arbiter grants one
// frame at a time. The frame is sent LSB-first into the encoder, followed by
// TAIL zero bits that terminate the trellis. The block then waits out the
// decoder latency, collects FRAME_LEN decoded bits and returns them tagged
// with the requester ID.
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-low reset (also resets the decoder)
//   req_valid    per-requester frame available
//   req_data     requester i frame at [i*FRAME_LEN +: FRAME_LEN]
//   req_ready    one-hot accept pulse, only in IDLE (combinational)
//   enc_en       registered encoder enable
//   enc_bit      registered encoder data bit, 0 whenever enc_en is 0
//   dec_bit      decoder output bit
//   rsp_valid    decoded frame available, held until rsp_ready
//   rsp_id       requester that owns rsp_data
//   rsp_data     decoded frame, bit 0 = first bit sent
//   rsp_ready    response consumer accept
//   busy         high while a frame is in flight or waiting for accept
//   frames_done  count of accepted responses, wraps silently
module viterbi_link_sched #(
  parameter int NREQ      = 4,
  parameter int FRAME_LEN = 16,
  parameter int TAIL      = 2,
  parameter int DEC_LAT   = 20,
  parameter int IDW       = $clog2(NREQ),
  parameter int CW        = $clog2(DEC_LAT + FRAME_LEN + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NREQ-1:0]           req_valid,
  input  logic [NREQ*FRAME_LEN-1:0] req_data,
  output logic [NREQ-1:0]           req_ready,
  output logic                      enc_en,
  output logic                      enc_bit,
  input  logic                      dec_bit,
  output logic                      rsp_valid,
  output logic [IDW-1:0]            rsp_id,
  output logic [FRAME_LEN-1:0]      rsp_data,
  input  logic                      rsp_ready,
  output logic                      busy,
  output logic [15:0]               frames_done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_RESP = 2'd2
  } state_t;

  // Cycle-counter landmarks inside RUN.
  localparam logic [CW-1:0] PAY_LAST  = CW'(FRAME_LEN - 1);
  localparam logic [CW-1:0] ENC_LAST  = CW'(FRAME_LEN + TAIL - 1);
  localparam logic [CW-1:0] CAP_FIRST = CW'(DEC_LAT);
  localparam logic [CW-1:0] CAP_LAST  = CW'(DEC_LAT + FRAME_LEN - 1);

  state_t                r_state;
  state_t                w_state_nx;
  logic [IDW-1:0]        r_ptr;
  logic [CW-1:0]         r_cyc;
  logic [FRAME_LEN-1:0]  r_sr;
  logic                  r_enc_en;
  logic                  r_enc_bit;
  logic                  r_rsp_valid;
  logic [IDW-1:0]        r_rsp_id;
  logic [FRAME_LEN-1:0]  r_rsp_data;
  logic [15:0]           r_frames_done;

  logic                  w_found;
  logic [IDW-1:0]        w_gnt;
  logic [IDW:0]          w_idx;
  logic [IDW-1:0]        w_ptr_nx;
  logic [FRAME_LEN-1:0]  w_frame;

  // Round-robin search: first valid requester starting at r_ptr, wrapping.
  always_comb begin
    w_found = 1'b0;
    w_gnt   = {IDW{1'b0}};
    w_idx   = {(IDW+1){1'b0}};
    for (int k = 0; k < NREQ; k++) begin
      w_idx = {1'b0, r_ptr} + (IDW+1)'(k);
      if (w_idx >= (IDW+1)'(NREQ)) begin
        w_idx = w_idx - (IDW+1)'(NREQ);
      end else begin
        w_idx = w_idx;
      end
      if (!w_found && req_valid[w_idx[IDW-1:0]]) begin
        w_found = 1'b1;
        w_gnt   = w_idx[IDW-1:0];
      end else begin
        w_found = w_found;
      end
    end
  end

  // Frame slice of the granted requester and the pointer that follows it.
  always_comb begin
    w_frame = {FRAME_LEN{1'b0}};
    for (int i = 0; i < NREQ; i++) begin
      if (IDW'(i) == w_gnt) begin
        w_frame = req_data[i*FRAME_LEN +: FRAME_LEN];
      end else begin
        w_frame = w_frame;
      end
    end
    if (w_gnt == IDW'(NREQ - 1)) begin
      w_ptr_nx = {IDW{1'b0}};
    end else begin
      w_ptr_nx = w_gnt + IDW'(1);
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  // FSM next state and the combinational accept pulse.
  // req_ready is also gated by rst so that nothing is accepted during reset.
  always_comb begin
    w_state_nx = r_state;
    req_ready  = {NREQ{1'b0}};
    case (r_state)
      S_IDLE: begin
        if (w_found && rst) begin
          w_state_nx       = S_RUN;
          req_ready[w_gnt] = 1'b1;
        end else begin
          w_state_nx = S_IDLE;
        end
      end
      S_RUN: begin
        if (r_cyc == CAP_LAST) begin
          w_state_nx = S_RESP;
        end else begin
          w_state_nx = S_RUN;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          w_state_nx = S_IDLE;
        end else begin
          w_state_nx = S_RESP;
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  // Datapath: grant latch, serializer, decoded-bit capture, response counter.
  // enc_en/enc_bit are precomputed one cycle ahead so that they hold the
  // value for the current r_cyc. Decoded bits shift in from the top, so the
  // first captured bit ends up in bit 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ptr         <= {IDW{1'b0}};
      r_cyc         <= {CW{1'b0}};
      r_sr          <= {FRAME_LEN{1'b0}};
      r_enc_en      <= 1'b0;
      r_enc_bit     <= 1'b0;
      r_rsp_valid   <= 1'b0;
      r_rsp_id      <= {IDW{1'b0}};
      r_rsp_data    <= {FRAME_LEN{1'b0}};
      r_frames_done <= 16'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_sr      <= w_frame >> 1;
            r_enc_bit <= w_frame[0];
            r_enc_en  <= 1'b1;
            r_rsp_id  <= w_gnt;
            r_cyc     <= {CW{1'b0}};
            r_ptr     <= w_ptr_nx;
          end
        end
        S_RUN: begin
          r_cyc    <= r_cyc + CW'(1);
          r_enc_en <= (r_cyc < ENC_LAST);
          if (r_cyc < PAY_LAST) begin
            r_enc_bit <= r_sr[0];
            r_sr      <= r_sr >> 1;
          end else begin
            r_enc_bit <= 1'b0;
          end
          if (r_cyc >= CAP_FIRST) begin
            r_rsp_data <= {dec_bit, r_rsp_data[FRAME_LEN-1:1]};
          end
          if (r_cyc == CAP_LAST) begin
            r_rsp_valid <= 1'b1;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            r_rsp_valid   <= 1'b0;
            r_frames_done <= r_frames_done + 16'd1;
          end
        end
        default: begin
          r_enc_en  <= 1'b0;
          r_enc_bit <= 1'b0;
        end
      endcase
    end
  end

  assign enc_en      = r_enc_en;
  assign enc_bit     = r_enc_bit;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_id      = r_rsp_id;
  assign rsp_data    = r_rsp_data;
  assign frames_done = r_frames_done;
  assign busy        = (r_state != S_IDLE);

endmodule

// File: tb/tb_viterbi_link_sched.sv
// Self-checking bench for viterbi_link_sched. It uses a loopback channel
// (dec_bit = enc_bit delayed DEC_LAT cycles), so every decoded frame must
// equal the payload that was sent. The reference model keeps the set of
// pending requests, their payloads, the round-robin pointer and the
// expected response count.
module tb_viterbi_link_sched;

  localparam int NREQ   = 4;
  localparam int FL     = 16;
  localparam int TAIL   = 2;
  localparam int DL     = 20;
  localparam int IDW    = 2;
  localparam int RUNLEN = DL + FL;

  logic                clk = 1'b0;
  logic                rst;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ*FL-1:0]  req_data;
  logic [NREQ-1:0]     req_ready;
  logic                enc_en;
  logic                enc_bit;
  logic                dec_bit;
  logic                rsp_valid;
  logic [IDW-1:0]      rsp_id;
  logic [FL-1:0]       rsp_data;
  logic                rsp_ready;
  logic                busy;
  logic [15:0]         frames_done;

  viterbi_link_sched #(
    .NREQ(NREQ), .FRAME_LEN(FL), .TAIL(TAIL), .DEC_LAT(DL)
  ) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .enc_en(enc_en), .enc_bit(enc_bit),
    .dec_bit(dec_bit), .rsp_valid(rsp_valid), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_ready(rsp_ready), .busy(busy),
    .frames_done(frames_done)
  );

  always #5 clk = ~clk;

  // Loopback channel stub, reset together with the scheduler.
  logic [DL-1:0] lb_pipe;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) lb_pipe <= '0;
    else      lb_pipe <= {lb_pipe[DL-2:0], enc_bit};
  end
  assign dec_bit = lb_pipe[DL-1];

  int checks   = 0;
  int failures = 0;

  // Reference model state.
  logic [NREQ-1:0] pend;
  logic [FL-1:0]   pdata [NREQ];
  int              mptr;
  logic [15:0]     exp_fd;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_reqs();
    for (int i = 0; i < NREQ; i++) req_data[i*FL +: FL] = pdata[i];
    req_valid = pend;
  endtask

  task automatic raise(input int i, input logic [FL-1:0] d);
    pend[i]  = 1'b1;
    pdata[i] = d;
    drive_reqs();
  endtask

  // First pending requester at or after p, modulo NREQ.
  function automatic int rr_pick(input logic [NREQ-1:0] m, input int p);
    for (int k = 0; k < NREQ; k++) begin
      if (m[(p + k) % NREQ]) return (p + k) % NREQ;
    end
    return -1;
  endfunction

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_enc_en"},    enc_en, 0);
    chk({tag, "_enc_bit"},   enc_bit, 0);
    chk({tag, "_rsp_valid"}, rsp_valid, 0);
    chk({tag, "_rsp_id"},    rsp_id, 0);
    chk({tag, "_rsp_data"},  rsp_data, 0);
    chk({tag, "_frames"},    frames_done, 0);
    chk({tag, "_busy"},      busy, 0);
    chk({tag, "_req_ready"}, req_ready, 0);
  endtask

  // One full frame: grant, RUN, RESP with bp cycles of backpressure, accept.
  // abort_cyc >= 0 pulls rst low during that RUN cycle and returns with rst low.
  task automatic run_frame(input int bp, input int abort_cyc);
    int            g;
    logic          found;
    logic [FL-1:0] pay;
    g = rr_pick(pend, mptr);
    found = 1'b0;
    for (int t = 0; t < 8 && !found; t++) begin
      @(negedge clk);
      if (req_ready != '0) found = 1'b1;
    end
    chk("grant_seen", found, 1);
    if (!found || g < 0) return;
    chk("grant_onehot", req_ready, 32'(1) << g);
    chk("idle_busy", busy, 0);
    chk("idle_enc_en", enc_en, 0);
    pay = pdata[g];
    @(posedge clk); #1;
    pend[g] = 1'b0;
    drive_reqs();
    mptr = (g + 1) % NREQ;
    for (int c = 0; c < RUNLEN; c++) begin
      @(negedge clk);
      chk("run_enc_en", enc_en, (c < FL + TAIL) ? 1 : 0);
      chk("run_enc_bit", enc_bit, (c < FL) ? 32'(pay[c]) : 0);
      chk("run_rsp_valid", rsp_valid, 0);
      chk("run_req_ready", req_ready, 0);
      chk("run_busy", busy, 1);
      if (c == abort_cyc) begin
        rst = 1'b0;
        #1;
        chk_reset_outputs("midrun_reset");
        mptr   = 0;
        exp_fd = 16'd0;
        return;
      end
    end
    @(negedge clk);
    chk("resp_valid", rsp_valid, 1);
    chk("resp_id", rsp_id, g);
    chk("resp_data", rsp_data, pay);
    chk("resp_busy", busy, 1);
    chk("resp_enc_en", enc_en, 0);
    repeat (bp) begin
      @(negedge clk);
      chk("bp_valid", rsp_valid, 1);
      chk("bp_id", rsp_id, g);
      chk("bp_data", rsp_data, pay);
      chk("bp_req_ready", req_ready, 0);
      chk("bp_enc_en", enc_en, 0);
      chk("bp_frames", frames_done, exp_fd);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    exp_fd = exp_fd + 16'd1;
    chk("accept_frames", frames_done, exp_fd);
    chk("accept_valid", rsp_valid, 0);
    chk("accept_busy", busy, 0);
  endtask

  initial begin
    rst       = 1'b0;
    req_valid = '0;
    req_data  = '0;
    rsp_ready = 1'b0;
    pend      = '0;
    mptr      = 0;
    exp_fd    = 16'd0;
    for (int i = 0; i < NREQ; i++) pdata[i] = '0;

    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("por");
    @(posedge clk); #1;
    rst = 1'b1;

    // Directed frame from requester 2 with 10 cycles of backpressure.
    raise(2, 16'hA5C3);
    run_frame(10, -1);

    // Pointer to 2 via requester 1, then 1 and 3 together: 3 before 1.
    raise(1, FL'($urandom));
    run_frame(0, -1);
    raise(1, FL'($urandom));
    raise(3, FL'($urandom));
    run_frame(1, -1);
    run_frame(2, -1);

    // Reset at RUN cycle 10, all four requesters waiting across the reset.
    raise(0, FL'($urandom));
    run_frame(0, 10);
    for (int i = 0; i < NREQ; i++) raise(i, FL'($urandom));
    @(negedge clk);
    chk("in_reset_req_ready", req_ready, 0);
    chk("in_reset_rsp_valid", rsp_valid, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    run_frame(0, -1);
    raise(0, FL'($urandom));
    for (int n = 0; n < 4; n++) run_frame(0, -1);

    // Randomized traffic with random backpressure.
    for (int n = 0; n < 24; n++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!pend[i] && ($urandom_range(0, 1) == 1)) raise(i, FL'($urandom));
      end
      if (pend == '0) raise(int'($urandom_range(0, NREQ - 1)), FL'($urandom));
      run_frame(int'($urandom_range(0, 4)), -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/viterbi_link_sched.md
Name: viterbi_link_sched

Overview:
- Frame-level scheduler that shares one rate-1/2 encoder → channel → Viterbi decoder link between NREQ requesters.
- Arbitrates round-robin and grants one requester at a time.
- Serializes the granted frame into the encoder, appends zero tail bits to terminate the trellis, and waits out the decoder latency.
- Collects the decoded bits and returns them tagged with the requester ID.
- Sits above the encoder/decoder pair in the tx/rx top level and replaces free-running enable_encoder_i stimulus.

Parameters:
- NREQ, 4, number of requesters (≥2).
- FRAME_LEN, 16, payload bits per frame.
- TAIL, 2, zero flush bits appended after payload (constraint length − 1).
- DEC_LAT, 20, cycles from enc_en/enc_bit sampled to matching decoded bit on dec_bit (must be ≥ TAIL and ≥1).
- IDW, $clog2(NREQ), requester ID width (derived).
- CW, $clog2(DEC_LAT+FRAME_LEN+1), cycle counter width (derived).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- req_valid  in  NREQ  per-requester frame available.
- req_data  in  NREQ*FRAME_LEN  frames; requester i uses bits [i*FRAME_LEN +: FRAME_LEN].
- req_ready  out  NREQ  one-hot accept pulse.
- enc_en  out  1  encoder enable (to enable_i).
- enc_bit  out  1  encoder data input (to d_in).
- dec_bit  in  1  decoder output (from d_out).
- rsp_valid  out  1  decoded frame available.
- rsp_id  out  IDW  requester that owns rsp_data.
- rsp_data  out  FRAME_LEN  decoded frame, bit 0 = first bit sent.
- rsp_ready  in  1  response consumer accept.
- busy  out  1  high in RUN or RESP.
- frames_done  out  16  count of completed responses, wraps 0xFFFF→0.

Behaviour:
- Reset (async, rst=0): state=IDLE, rr pointer=0, cyc=0, all registered outputs 0 (enc_en, enc_bit, rsp_valid, rsp_id, rsp_data, frames_done). req_ready=0.
- States: IDLE, RUN, RESP.
- IDLE:
  - Grant target is the first i with req_valid[i]=1, searching ptr, ptr+1, … mod NREQ.
  - If any request is valid: req_ready[g]=1 combinationally for that cycle only, and the frame handshake completes that cycle.
  - Latch req_data slice g into shift register sr, latch g into rsp_id, cyc←0, ptr←(g+1) mod NREQ, go to RUN.
  - With no valid requests: ptr unchanged, req_ready=0.
- RUN (cyc increments by 1 each cycle):
  - enc_en=1 for cyc in [0, FRAME_LEN+TAIL−1], else 0.
  - enc_bit=sr[0] for cyc<FRAME_LEN, then 0 during tail. sr shifts right once per payload cycle.
  - enc_en/enc_bit are registered so they change only on clk edges; enc_bit=0 whenever enc_en=0.
  - Capture: for cyc in [DEC_LAT, DEC_LAT+FRAME_LEN−1], rsp_data[cyc−DEC_LAT]←dec_bit. Capture overlaps tail and trailing enc_en=0 cycles.
  - At cyc=DEC_LAT+FRAME_LEN−1 (final capture): go to RESP, rsp_valid←1.
  - Total RUN length = DEC_LAT+FRAME_LEN cycles.
- RESP:
  - rsp_valid, rsp_id and rsp_data are held stable until rsp_ready=1 is sampled.
  - On that edge: rsp_valid←0, frames_done←frames_done+1, go to IDLE.
  - rsp_ready while rsp_valid=0 is ignored.
- req_ready is never asserted outside IDLE. Requests that arrive during RUN/RESP wait and are not dropped.
- Minimum frame period: 1 grant cycle + DEC_LAT+FRAME_LEN + 1 response cycle. No back-to-back overlap.
- req_valid is deasserted by the requester after the req_ready pulse. req_data is sampled only on the grant cycle.
- Simultaneous req_valid from all NREQ with ptr=k: grant order is k, k+1, …, wrapping.
- frames_done wraps silently.
- Reset mid-RUN/RESP: immediate return to reset values. The partial frame is lost, no response is issued, and the decoder is reset by the same rst.

Test Plan:
1. Loopback stub (dec_bit = enc_bit delayed DEC_LAT): NREQ=4, FRAME_LEN=16. Requester 2 sends 0xA5C3 → enc_bit sequence LSB-first 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1, then 2 zeros; rsp_valid after 36 RUN cycles with rsp_id=2, rsp_data=0xA5C3.
2. Tail and idle check: enc_en high for exactly 18 cycles per frame, enc_bit=0 on cycles 16–17 and whenever enc_en=0.
3. Round robin: all four req_valid held high from reset → grants in order 0,1,2,3,0. Only requester 1 and 3 valid with ptr=2 → grant 3, then 1.
4. Backpressure: hold rsp_ready=0 for 10 cycles in RESP → rsp_valid, rsp_id and rsp_data stable, req_ready stays 0, enc_en=0. Then rsp_ready=1 → IDLE next cycle and frames_done increments by 1.
5. Full codec in path: real encoder2/decoder, DEC_LAT set to measured value, one channel bit flipped per frame → rsp_data equals sent payload for 256 random frames.
6. rst pulsed low at cyc=10 of RUN → all outputs 0 asynchronously, ptr=0, no rsp_valid. The next frame after release completes correctly.
